// File: rtl/ccd_readout_if.sv
// ccd_readout_if: groups the pixel ADC handshake and the tx FIFO write port
// that the CCD readout sequencer drives.
interface ccd_readout_if;
    logic        adc_sample;
    logic        adc_busy;
    logic [15:0] adc_data;
    logic [7:0]  tx_wdata;
    logic        tx_winc;
    logic        tx_wfull;

    modport master (
        output adc_sample,
        input  adc_busy,
        input  adc_data,
        output tx_wdata,
        output tx_winc,
        input  tx_wfull
    );

    modport slave (
        input  adc_sample,
        output adc_busy,
        output adc_data,
        input  tx_wdata,
        input  tx_winc,
        output tx_wfull
    );
endinterface

// File: rtl/ccd_readout.sv
// ccd_readout: frame readout sequencer for the KAF CDIP24 CCD.
// Generates v1/v2, h1/h2 and rg for a full frame, starts one ADC conversion
// per pixel and writes each 16-bit result LSB byte first into the tx FIFO.
// Optional macro CCD_FRAME_MARK_EN wraps each frame in A5 5A ... 5A A5 marks.
//
// state | meaning
// IDLE  | waiting for start
// HDR0  | write 0xA5 frame header (CCD_FRAME_MARK_EN only)
// HDR1  | write 0x5A frame header (CCD_FRAME_MARK_EN only)
// VS1   | vertical phase 1 high for V_HALF cycles
// VS2   | vertical phase 2 high for V_HALF cycles
// HS1   | horizontal phase 1 plus reset gate for H_HALF cycles
// HS2   | horizontal phase 2 for H_HALF cycles
// SMP   | request ADC conversion until adc_busy rises
// AWT   | wait for adc_busy low, capture adc_data
// WLO   | write pixel low byte (stalls while FIFO full)
// WHI   | write pixel high byte, step column/row
// TRL0  | write 0x5A frame trailer (CCD_FRAME_MARK_EN only)
// TRL1  | write 0xA5 frame trailer (CCD_FRAME_MARK_EN only)
// DONE  | one busy cycle before IDLE
module ccd_readout #(
    parameter int N_ROWS = 512,
    parameter int N_COLS = 768,
    parameter int V_HALF = 100,
    parameter int H_HALF = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            v1,
    output logic            v2,
    output logic            h1,
    output logic            h2,
    output logic            rg,
    ccd_readout_if.master   bus
);

    localparam logic [15:0] ROW_LAST = 16'(N_ROWS - 1);
    localparam logic [15:0] COL_LAST = 16'(N_COLS - 1);
    localparam logic [15:0] V_LAST   = 16'(V_HALF - 1);
    localparam logic [15:0] H_LAST   = 16'(H_HALF - 1);

    typedef enum logic [3:0] {
        IDLE, VS1, VS2, HS1, HS2, SMP, AWT, WLO, WHI, DONE
`ifdef CCD_FRAME_MARK_EN
        , HDR0, HDR1, TRL0, TRL1
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] timer, row, col, pix;
    logic        armed;
    logic        adc_sample_c, tx_winc_c;
    logic [7:0]  tx_wdata_c;
    logic        timed;

    assign bus.adc_sample = adc_sample_c;
    assign bus.tx_winc    = tx_winc_c;
    assign bus.tx_wdata   = tx_wdata_c;
    assign timed = (state == VS1) || (state == VS2) || (state == HS1) || (state == HS2);

    // State, counters and pixel register; armed blocks a start coinciding with reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            row   <= '0;
            col   <= '0;
            pix   <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (!timed || state_nxt != state)
                timer <= '0;
            else
                timer <= timer + 16'd1;
            if (state == IDLE && state_nxt != IDLE)
                row <= '0;
            if (state == VS2 && state_nxt == HS1)
                col <= '0;
            if (state == WHI && tx_winc_c) begin
                if (col != COL_LAST)
                    col <= col + 16'd1;
                else if (row != ROW_LAST)
                    row <= row + 16'd1;
            end
            if (state == AWT && !bus.adc_busy)
                pix <= bus.adc_data;
        end
    end

    // Next state and output decode from state and registered counters.
    always_comb begin
        state_nxt    = state;
        busy         = (state != IDLE);
        v1           = 1'b0;
        v2           = 1'b0;
        h1           = 1'b0;
        h2           = 1'b0;
        rg           = 1'b0;
        adc_sample_c = 1'b0;
        tx_wdata_c   = 8'h00;
        tx_winc_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start && armed)
`ifdef CCD_FRAME_MARK_EN
                    state_nxt = HDR0;
`else
                    state_nxt = VS1;
`endif
            end
            VS1: begin
                v1 = 1'b1;
                if (timer == V_LAST) state_nxt = VS2;
            end
            VS2: begin
                v2 = 1'b1;
                if (timer == V_LAST) state_nxt = HS1;
            end
            HS1: begin
                h1 = 1'b1;
                rg = 1'b1;
                if (timer == H_LAST) state_nxt = HS2;
            end
            HS2: begin
                h2 = 1'b1;
                if (timer == H_LAST) state_nxt = SMP;
            end
            SMP: begin
                adc_sample_c = 1'b1;
                if (bus.adc_busy) state_nxt = AWT;
            end
            AWT: begin
                if (!bus.adc_busy) state_nxt = WLO;
            end
            WLO: begin
                tx_wdata_c = pix[7:0];
                tx_winc_c  = !bus.tx_wfull;
                if (tx_winc_c) state_nxt = WHI;
            end
            WHI: begin
                tx_wdata_c = pix[15:8];
                tx_winc_c  = !bus.tx_wfull;
                if (tx_winc_c) begin
                    if (col != COL_LAST)
                        state_nxt = HS1;
                    else if (row != ROW_LAST)
                        state_nxt = VS1;
                    else
`ifdef CCD_FRAME_MARK_EN
                        state_nxt = TRL0;
`else
                        state_nxt = DONE;
`endif
                end
            end
`ifdef CCD_FRAME_MARK_EN
            HDR0: begin
                tx_wdata_c = 8'hA5;
                tx_winc_c  = !bus.tx_wfull;
                if (tx_winc_c) state_nxt = HDR1;
            end
            HDR1: begin
                tx_wdata_c = 8'h5A;
                tx_winc_c  = !bus.tx_wfull;
                if (tx_winc_c) state_nxt = VS1;
            end
            TRL0: begin
                tx_wdata_c = 8'h5A;
                tx_winc_c  = !bus.tx_wfull;
                if (tx_winc_c) state_nxt = TRL1;
            end
            TRL1: begin
                tx_wdata_c = 8'hA5;
                tx_winc_c  = !bus.tx_wfull;
                if (tx_winc_c) state_nxt = DONE;
            end
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/ccd_readout.md
Name: ccd_readout

Overview:
Readout sequencer for the KAF CDIP24 CCD. It consumes a one-cycle start pulse from the command state machine. It then generates the vertical clocks (v1/v2), horizontal clocks (h1/h2) and reset gate (rg) for a full frame. For each pixel it starts the external pixel ADC interface and pushes the 16-bit result, LSB byte first, into the tx FIFO write port that feeds the FT245 stage.

Parameters:
N_ROWS, 512, rows per frame (1..65535)
N_COLS, 768, pixels per row (1..65535)
V_HALF, 100, clk cycles per vertical clock phase (>=1)
H_HALF, 8, clk cycles per horizontal clock phase (>=1)

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to read a frame; honoured only in IDLE
busy  output  1  high from the cycle after start is accepted until return to IDLE
v1  output  1  vertical clock phase 1
v2  output  1  vertical clock phase 2
h1  output  1  horizontal clock phase 1
h2  output  1  horizontal clock phase 2
rg  output  1  output-node reset gate
adc_sample  output  1  request to ADC interface
adc_busy  input  1  ADC interface busy
adc_data  input  16  last ADC conversion result
tx_wdata  output  8  tx FIFO write data
tx_winc  output  1  tx FIFO write strobe
tx_wfull  input  1  tx FIFO full

Behaviour:
- Async reset: state=IDLE; row/col/timer counters=0; all outputs 0.
- Outputs are decoded from state and registered counters only. tx_winc additionally depends on tx_wfull.
- States and transitions:
  - IDLE: busy=0. start=1 -> VS1, with row=0 and timer=0.
  - VS1: v1=1, v2=0. After V_HALF cycles -> VS2.
  - VS2: v1=0, v2=1. After V_HALF cycles -> HS1, with col=0.
  - HS1: h1=1, h2=0, rg=1. After H_HALF cycles -> HS2.
  - HS2: h1=0, h2=1, rg=0. After H_HALF cycles -> SMP.
  - SMP: adc_sample=1. adc_busy=1 -> AWT. Waits indefinitely.
  - AWT: adc_busy=0 -> capture adc_data into a 16-bit pix register -> WLO.
  - WLO: tx_wdata=pix[7:0]; tx_winc=!tx_wfull. Advance to WHI only on the cycle tx_winc=1.
  - WHI: tx_wdata=pix[15:8]; tx_winc=!tx_wfull. On the write:
    - col<N_COLS-1: col+1 -> HS1.
    - else if row<N_ROWS-1: row+1 -> VS1.
    - else -> DONE.
  - DONE: one cycle, busy=1 -> IDLE.
- In every state other than VS1/VS2/HS1/HS2, v1/v2/h1/h2/rg are all 0.
- Timers count 0..HALF-1 and clear on every state change.
- Counters are 16 bits and never wrap within a legal frame.
- A frame produces exactly 2*N_ROWS*N_COLS bytes in raster order (row-major, col 0 first).
- tx_wfull held high stalls the machine in WLO/WHI with no byte loss or duplication. Clock outputs stay 0 during the stall.
- start while busy=1 is ignored; it is not queued.
- start and rst_n deasserting in the same cycle: start is ignored.
- rst_n low mid-frame: immediate return to IDLE with all outputs 0. Partial frame bytes already in the FIFO are not retracted.
- Latency: from start to the first v1=1 is 1 cycle (v1 high in the cycle after start).

Optional Feature:
CCD_FRAME_MARK_EN. Defined:
- IDLE->start goes through HDR0/HDR1 first, writing 0xA5 then 0x5A (same full-gated write rule), then VS1.
- DONE is preceded by TRL0/TRL1, writing 0x5A then 0xA5.
- A frame is then 2*N_ROWS*N_COLS+4 bytes.
Undefined: these states do not exist and the byte count is as above.

Test Plan:
- Params N_ROWS=2, N_COLS=3, V_HALF=4, H_HALF=2; ADC model returns 0x1234+pixel index, busy 5 cycles; tx_wfull=0; pulse start -> 12 bytes 34 12 35 12 36 12 37 12 38 12 39 12; busy falls after DONE; v1 high exactly 4 cycles per row, 2 rows.
- Same params, hold tx_wfull=1 for 20 cycles while in WLO of pixel 1 -> no tx_winc during the stall; byte stream identical to the first test; h1/h2/rg stay 0 while stalled.
- Pulse start again at cycle 10 of a frame -> ignored; exactly 12 bytes total, then one more frame only after a new start in IDLE.
- Assert rst_n=0 while in HS2 of row 1 -> all outputs 0 that cycle; after release, start yields a fresh full 12-byte frame.
- Hold adc_busy=0 forever after entering SMP -> adc_sample stays 1, no tx_winc, busy stays 1.
- With CCD_FRAME_MARK_EN defined, rerun the first test -> A5 5A, the 12 pixel bytes, then 5A A5 (16 bytes).
